// File: rtl/seqdet_param_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   len_w(pat_w) : width of a length field able to hold 0..pat_w
//   len_mask(len): low-order mask of len ones, MAX_PAT_W bits wide
//   OVL_ON/OFF   : overlap mode encodings
package seqdet_pkg;
  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  // Upper bound on PAT_W supported by len_mask.
  localparam int MAX_PAT_W = 64;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic logic [MAX_PAT_W-1:0] len_mask(input int len);
    logic [MAX_PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PAT_W; i++)
      if (i < len) m[i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/seqdet_param_if.sv
// Bitstream, configuration and result signals of seqdet_param.
//   master: stimulus side (drives x/x_valid/pattern config/cnt_clr)
//   slave : detector side (drives z/match_cnt/armed)
interface seqdet_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  import seqdet_pkg::*;
  localparam int LEN_W = len_w(PAT_W);

  logic             x;
  logic             x_valid;
  logic             pat_load;
  logic [PAT_W-1:0] pat_data;
  logic [LEN_W-1:0] pat_len;
  logic             pat_ovl;
  logic             cnt_clr;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output x, x_valid, pat_load, pat_data, pat_len, pat_ovl, cnt_clr,
    input  z, match_cnt, armed
  );
  modport slave (
    input  x, x_valid, pat_load, pat_data, pat_len, pat_ovl, cnt_clr,
    output z, match_cnt, armed
  );
endinterface

// File: rtl/seqdet_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst (async, active-low), clr (sync clear), inc (count enable) -> q
// clr together with inc yields 1 so a match on the clear cycle is not lost.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                q <= '0;
    else if (clr)            q <= inc ? W'(1) : '0;
    else if (inc && q != '1) q <= q + 1'b1;
  end
endmodule

// File: rtl/seqdet_param.sv
// Parametrised serial bit-pattern detector.
//   clk      : rising-edge clock
//   rst      : asynchronous reset, active-low
//   bus      : seqdet_param_if slave - serial input x/x_valid, pattern load
//              (pat_load/pat_data/pat_len/pat_ovl), cnt_clr; outputs z (one-cycle
//              match pulse), match_cnt (saturating), armed (next valid bit can match)
// Pattern is right-aligned: bit0 is the most recently received bit.
module seqdet_param
  import seqdet_pkg::*;
#(
  parameter int             PAT_W   = 8,
  parameter int             CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'('b10010),
  parameter int             RST_LEN = 5,
  parameter logic           RST_OVL = OVL_ON
) (
  input logic            clk,
  input logic            rst,
  seqdet_param_if.slave  bus
);
  localparam int LEN_W = len_w(PAT_W);
  localparam logic [LEN_W-1:0] PAT_W_L   = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN);

  logic [PAT_W-1:0] pat_q, hist_q, hist_n;
  logic [LEN_W-1:0] len_q, len_n, fill_q, fill_inc, fill_n, load_len;
  logic             ovl_q, hit, armed_n;
  logic [MAX_PAT_W-1:0] mask;

  // Out-of-range lengths fall back to the full pattern width.
  assign load_len = (bus.pat_len == '0 || bus.pat_len > PAT_W_L) ? PAT_W_L : bus.pat_len;

  always_comb begin
    hist_n   = hist_q;
    len_n    = len_q;
    fill_n   = fill_q;
    fill_inc = fill_q;
    hit      = 1'b0;
    armed_n  = bus.armed;
    mask     = len_mask(int'(len_q));
    if (bus.pat_load) begin
      hist_n  = '0;
      fill_n  = '0;
      len_n   = load_len;
      armed_n = (LEN_W'(1) >= load_len);
    end else if (bus.x_valid) begin
      hist_n   = {hist_q[PAT_W-2:0], bus.x};
      fill_inc = (fill_q == PAT_W_L) ? fill_q : fill_q + 1'b1;
      hit      = (fill_inc >= len_q) &&
                 ((MAX_PAT_W'(hist_n ^ pat_q) & mask) == '0);
      // Non-overlap restarts fill so the next match needs len fresh bits.
      fill_n   = (hit && ovl_q == OVL_OFF) ? '0 : fill_inc;
      // fill + 1 >= len, written to avoid underflow of len - 1.
      armed_n  = ({1'b0, fill_n} + 1'b1) >= {1'b0, len_q};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q     <= RST_PAT;
      len_q     <= RST_LEN_L;
      ovl_q     <= RST_OVL;
      hist_q    <= '0;
      fill_q    <= '0;
      bus.z     <= 1'b0;
      bus.armed <= 1'b0;
    end else begin
      if (bus.pat_load) begin
        pat_q <= bus.pat_data;
        ovl_q <= bus.pat_ovl;
      end
      len_q     <= len_n;
      hist_q    <= hist_n;
      fill_q    <= fill_n;
      bus.z     <= hit;
      bus.armed <= armed_n;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.cnt_clr),
    .inc (hit),
    .q   (bus.match_cnt)
  );
endmodule

// File: tb/tb_seqdet_param.sv
module tb_seqdet_param;
  localparam int PAT_W = 8;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   zn    = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seqdet_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seqdet_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, queue the expected z, compare #1 after the edge.
  task automatic cyc(input logic ld, input logic clr, input logic v, input logic xb,
                     input logic ez);
    logic e;
    @(negedge clk);
    bus.pat_load = ld;
    bus.cnt_clr  = clr;
    bus.x_valid  = v;
    bus.x        = xb;
    exp_q.push_back(ez);
    @(posedge clk);
    #1;
    zn++;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL z#%0d scoreboard empty", zn);
    end else begin
      e = exp_q.pop_front();
      assert (bus.z === e) else begin
        bad++;
        $error("FAIL z#%0d obs=%0b exp=%0b", zn, bus.z, e);
      end
    end
  endtask

  task automatic step(input logic xb, input logic v, input logic ez);
    cyc(1'b0, 1'b0, v, xb, ez);
  endtask

  task automatic clear();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic [3:0] l, input logic o,
                      input logic xb);
    bus.pat_data = p;
    bus.pat_len  = l;
    bus.pat_ovl  = o;
    cyc(1'b1, 1'b0, 1'b1, xb, 1'b0);
  endtask

  // Bits sent msb first; zb marks the bits expected to complete a match.
  task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] zb);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, zb[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.x = 1'b0; bus.x_valid = 1'b0; bus.pat_load = 1'b0; bus.cnt_clr = 1'b0;
    bus.pat_data = '0; bus.pat_len = '0; bus.pat_ovl = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_z", bus.z, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    chk("rst_armed", bus.armed, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: defaults, overlap
    stream(16'b10010010, 8, 16'b00001001);
    chk("t1_cnt", bus.match_cnt, 2);
    chk("t1_armed", bus.armed, 1);
    clear();
    chk("t1_clr", bus.match_cnt, 0);
    // same stream, non-overlap: second match lacks fresh bits
    load(8'b10010, 4'd5, 1'b0, 1'b0);
    stream(16'b10010010, 8, 16'b00001000);
    chk("t1n_cnt", bus.match_cnt, 1);
    chk("t1n_armed", bus.armed, 0);
    clear();

    // 2: non-overlap then overlap on 1001010010
    load(8'b10010, 4'd5, 1'b0, 1'b0);
    stream(16'b1001010010, 10, 16'b0000100001);
    chk("t2n_cnt", bus.match_cnt, 2);
    clear();
    load(8'b10010, 4'd5, 1'b1, 1'b0);
    stream(16'b1001010010, 10, 16'b0000100001);
    chk("t2o_cnt", bus.match_cnt, 2);
    clear();

    // 3: 1011 with a valid gap
    load(8'b1011, 4'd4, 1'b1, 1'b0);
    chk("t3_armed0", bus.armed, 0);
    stream(16'b1011, 4, 16'b0001);
    chk("t3_armed1", bus.armed, 1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk("t3_armed_gap", bus.armed, 1);
    stream(16'b011, 3, 16'b001);
    chk("t3_cnt", bus.match_cnt, 2);
    clear();

    // 4: single-bit pattern, saturation at 3, clear with match
    load(8'b1, 4'd1, 1'b1, 1'b0);
    chk("t4_armed", bus.armed, 1);
    stream(16'hFF, 8, 16'hFF);
    chk("t4_sat", bus.match_cnt, 3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4_clr_hit", bus.match_cnt, 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_clr", bus.match_cnt, 0);

    // 5: reset mid-stream aborts the partial match
    load(8'b10010, 4'd5, 1'b1, 1'b0);
    stream(16'b1001, 4, 16'b0000);
    chk("t5_armed_pre", bus.armed, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_z", bus.z, 0);
    chk("t5_rst_armed", bus.armed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    stream(16'b10010, 5, 16'b00001);
    chk("t5_cnt", bus.match_cnt, 1);
    clear();

    // 6: out-of-range lengths load PAT_W; x on the load cycle is dropped
    load(8'b10110011, 4'd0, 1'b1, 1'b1);
    stream(16'b101100, 6, 16'b0);
    chk("t6a_armed6", bus.armed, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("t6a_armed7", bus.armed, 1);
    step(1'b1, 1'b1, 1'b1);
    load(8'b10110011, 4'(PAT_W + 3), 1'b1, 1'b1);
    stream(16'b101100, 6, 16'b0);
    chk("t6b_armed6", bus.armed, 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t6_cnt", bus.match_cnt, 2);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
